// File: rtl/gf180mcu_fd_sc_mcu9t5v0__subser_pkg.sv
`default_nettype none
// ============================================================================
// gf180mcu_fd_sc_mcu9t5v0__subser_pkg
// Shared FSM encoding and WIDTH bounds for the bit-serial subtractor.
// Revision: 1.0
// ============================================================================
package gf180mcu_fd_sc_mcu9t5v0__subser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__subf_bit.sv
`default_nettype none
// ============================================================================
// gf180mcu_fd_sc_mcu9t5v0__subf_bit
// Combinational full-subtractor slice: D = X ^ Y ^ BI, BO = borrow out.
// Revision: 1.0
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__subf_bit (
  input  wire X,
  input  wire Y,
  input  wire BI,
  output wire D,
  output wire BO
);

  wire w_nx;
  wire w_xy;
  wire w_t0;
  wire w_t1;
  wire w_t2;

  not u_inv (w_nx, X);
  xor u_x0  (w_xy, X, Y);
  xor u_x1  (D, w_xy, BI);
  and u_a0  (w_t0, w_nx, Y);
  and u_a1  (w_t1, w_nx, BI);
  and u_a2  (w_t2, Y, BI);
  or  u_o0  (BO, w_t0, w_t1, w_t2);

endmodule
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__subser_1.sv
`default_nettype none
// ============================================================================
// gf180mcu_fd_sc_mcu9t5v0__subser_1
// Bit-serial unsigned subtractor, LSB first: {BO,D} = A - B - BI.
// Revision: 1.0
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__subser_1
  import gf180mcu_fd_sc_mcu9t5v0__subser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("WIDTH must lie within the legal range");
  end

  // Supply pins carry no logic function in the behavioural view.
  wire w_unused_supply = VDD ^ VSS;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_borrow;
  logic               r_bo;
  logic               r_busy;
  logic               r_done;
  logic               w_di;
  logic               w_bo;

  gf180mcu_fd_sc_mcu9t5v0__subf_bit u_slice (
    .X  (r_sa[0]),
    .Y  (r_sb[0]),
    .BI (r_borrow),
    .D  (w_di),
    .BO (w_bo)
  );

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_last) begin
          w_last = 1'b1;
          w_next = FIN;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bo     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_sa     <= A;
        r_sb     <= B;
        r_borrow <= BI;
        r_cnt    <= '0;
        r_res    <= '0;
        r_bo     <= 1'b0;
        r_busy   <= 1'b1;
      end else if (r_state == RUN) begin
        r_sa     <= r_sa >> 1;
        r_sb     <= r_sb >> 1;
        r_res    <= {w_di, r_res[WIDTH-1:1]};
        r_borrow <= w_bo;
        // Hold the counter on the final bit so it never wraps.
        if (w_last) begin
          r_bo   <= w_bo;
          r_busy <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign BUSY = r_busy;
  assign DONE = r_done;
  assign D    = r_res;
  assign BO   = r_bo;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__subser_1.sv
`default_nettype none
// ============================================================================
// tb_gf180mcu_fd_sc_mcu9t5v0__subser_1
// Scoreboard bench for the bit-serial subtractor at WIDTH=8 and WIDTH=13.
// Revision: 1.0
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__subser_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wire vdd;
  wire vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  int checks = 0;
  int errors = 0;
  bit lanes_done [2];

  task automatic chk(input bit ok, input string name, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int W = (g == 0) ? 8 : 13;

    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bi    = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;

    gf180mcu_fd_sc_mcu9t5v0__subser_1 #(.WIDTH(W)) u_dut (
      .CLK   (clk),
      .RST   (rst),
      .START (start),
      .A     (a),
      .B     (b),
      .BI    (bi),
      .BUSY  (busy),
      .DONE  (done),
      .D     (d),
      .BO    (bo),
      .VDD   (vdd),
      .VSS   (vss)
    );

    typedef struct {
      logic [W:0] exp;
      int         edge_acc;
    } txn_t;

    txn_t       q[$];
    int         edge_no    = 0;
    int         next_free  = 0;
    int         ops        = 0;
    int         busy_run   = 0;
    logic [W:0] held       = '0;
    bit         held_valid = 1'b0;

    always @(posedge clk) edge_no <= edge_no + 1;

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit z);
      logic [63:0] t;
      t = 64'(x) - 64'(y) - 64'(z);
      return t[W:0];
    endfunction

    // Drives one cycle of inputs and tracks, from the operation rules alone,
    // whether the coming edge accepts a new subtraction.
    task automatic step(input bit s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input bit bbi, input bit r);
      int e;
      @(negedge clk);
      #1;
      start = s;
      a     = aa;
      b     = bb;
      bi    = bbi;
      rst   = r;
      e     = edge_no + 1;
      if (r) begin
        q.delete();
        next_free  = e + 1;
        held       = '0;
        held_valid = 1'b1;
      end else if (s && e >= next_free) begin
        q.push_back('{exp: model(aa, bb, bbi), edge_acc: e});
        next_free = e + W + 2;
        ops++;
      end
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic rnd_step(input bit s, input bit r);
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom();
      rb = $urandom();
      step(s, ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), r);
    endtask

    always @(negedge clk) begin
      if (busy) begin
        busy_run++;
      end else if (done) begin
        chk(!busy, $sformatf("w%0d busy_with_done", W), $sformatf("%0b", busy), "0");
        chk(busy_run == W, $sformatf("w%0d busy_cycles", W), $sformatf("%0d", busy_run), $sformatf("%0d", W));
        busy_run = 0;
        if (q.size() == 0) begin
          chk(1'b0, $sformatf("w%0d unexpected_done", W), "DONE", "no DONE");
        end else begin
          txn_t t;
          t = q.pop_front();
          chk({bo, d} == t.exp, $sformatf("w%0d result", W),
              $sformatf("BO=%0b D=%h", bo, d), $sformatf("BO=%0b D=%h", t.exp[W], t.exp[W-1:0]));
          chk(edge_no - t.edge_acc == W, $sformatf("w%0d latency", W),
              $sformatf("%0d", edge_no - t.edge_acc), $sformatf("%0d", W));
          held       = t.exp;
          held_valid = 1'b1;
        end
      end else begin
        busy_run = 0;
        if (held_valid)
          chk({bo, d} == held, $sformatf("w%0d hold", W),
              $sformatf("BO=%0b D=%h", bo, d), $sformatf("BO=%0b D=%h", held[W], held[W-1:0]));
      end
      if (q.size() != 0 && edge_no > q[0].edge_acc + W) begin
        chk(1'b0, $sformatf("w%0d done_timeout", W), "no DONE", "DONE");
        void'(q.pop_front());
      end
    end

    initial begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b0, '0, '0, 1'b0, 1'b1);
      idle(1);
      // Basic operations, including underflow and borrow-in.
      step(1'b1, W'('h5A), W'('h3C), 1'b0, 1'b0);
      idle(W + 3);
      step(1'b1, W'('h00), W'('h01), 1'b0, 1'b0);
      idle(W + 3);
      step(1'b1, W'('h80), W'('h80), 1'b1, 1'b0);
      idle(W + 3);
      // START during RUN must be ignored.
      step(1'b1, W'('h5A), W'('h3C), 1'b0, 1'b0);
      idle(3);
      step(1'b1, W'('hFF), W'('h00), 1'b0, 1'b0);
      idle(W + 3);
      // Reset in the middle of RUN, then a fresh operation.
      step(1'b1, W'('h10), W'('h20), 1'b0, 1'b0);
      idle(4);
      step(1'b0, '0, '0, 1'b0, 1'b1);
      idle(2);
      step(1'b1, W'('h10), W'('h01), 1'b0, 1'b0);
      idle(W + 3);
      // START held high back to back.
      for (int i = 0; i < 4 * (W + 2); i++) rnd_step(1'b1, 1'b0);
      idle(W + 3);
      // Random sweep with occasional resets.
      ops = 0;
      while (ops < 2000)
        rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
      idle(W + 4);
      chk(q.size() == 0, $sformatf("w%0d drain", W), $sformatf("%0d pending", q.size()), "0 pending");
      lanes_done[g] = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(lanes_done[0] && lanes_done[1]) && cyc < 95000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(lanes_done[0] && lanes_done[1]))
      chk(1'b0, "global_timeout", "lanes running", "lanes finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
